// File: rtl/rv32i_pkg.sv
// Shared encodings for the RV32I decode/execute slice: opcodes, ALU operations,
// mux selects and funct3 values, plus the funct3/funct7 to ALU-op mapping.
package rv32i_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_AND   = 4'b0010,
        ALU_OR    = 4'b0011,
        ALU_XOR   = 4'b0100,
        ALU_SLT   = 4'b0101,
        ALU_SLTU  = 4'b0110,
        ALU_SLL   = 4'b0111,
        ALU_SRL   = 4'b1000,
        ALU_SRA   = 4'b1001,
        ALU_PASSB = 4'b1010
    } alu_ctrl_t;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_U = 3'b011,
        IMM_J = 3'b100
    } imm_src_t;

    typedef enum logic [1:0] {
        RES_ALU   = 2'b00,
        RES_MEM   = 2'b01,
        RES_PC4   = 2'b10,
        RES_PCIMM = 2'b11
    } result_src_t;

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'b00,
        PC_IMM   = 2'b01,
        PC_ALU   = 2'b10
    } pc_src_t;

    // Branch funct3
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Load/store funct3 (forwarded unchanged on mode_bu)
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Integer ALU funct3
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // alt is funct7[5] already qualified by the caller (SUB/SRA select).
    function automatic alu_ctrl_t arith_op(input logic [2:0] f3, input logic alt);
        case (f3)
            F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return alt ? ALU_SRA : ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/rv_regfile.sv
// 2-read/1-write architectural register file; x0 reads as zero and is never written.
// a0/a1/a7 taps expose x10/x11/x17 for observation.
module rv_regfile #(
    parameter int WIDTH = 32,
    parameter int NREGS = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [$clog2(NREGS)-1:0] ra1,
    input  logic [$clog2(NREGS)-1:0] ra2,
    input  logic [$clog2(NREGS)-1:0] wa,
    input  logic                     we,
    input  logic [WIDTH-1:0]         wd,
    output logic [WIDTH-1:0]         rd1,
    output logic [WIDTH-1:0]         rd2,
    output logic [WIDTH-1:0]         a0,
    output logic [WIDTH-1:0]         a1,
    output logic [WIDTH-1:0]         a7
);

    logic [WIDTH-1:0] regs [NREGS];

    // NOTE: the array is flops, not a RAM macro, so it can take the async reset;
    // reset wins over any write that would land on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else if (we && wa != '0) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
    assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

    assign a0 = regs[10];
    assign a1 = regs[11];
    assign a7 = regs[17];

endmodule

// File: rtl/rv32i_decode_exec.sv
// Single-cycle RV32I decode/execute: main decoder, register file, ALU,
// branch resolution and write-back mux.
module rv32i_decode_exec
    import rv32i_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREGS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] imm_ext,
    input  logic [WIDTH-1:0] read_data,
    output logic [2:0]       imm_src,
    output logic [1:0]       pc_src,
    output logic             mem_write,
    output logic [2:0]       mode_bu,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic [WIDTH-1:0] write_data,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] a0,
    output logic [WIDTH-1:0] a1,
    output logic [WIDTH-1:0] a7
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       alt;
    logic       unused_instr_bits;

    assign opcode            = instr[6:0];
    assign funct3            = instr[14:12];
    assign alt               = instr[30];
    assign unused_instr_bits = ^{instr[31], instr[29:25]};

    logic [WIDTH-1:0] rs1_val, rs2_val;
    logic             reg_write, alu_src, is_branch;
    alu_ctrl_t        alu_ctrl;
    imm_src_t         imm_sel;
    result_src_t      res_sel;
    pc_src_t          pc_base;

    rv_regfile #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_regfile (
        .clk (clk),
        .rst (rst),
        .ra1 (instr[19:15]),
        .ra2 (instr[24:20]),
        .wa  (instr[11:7]),
        .we  (reg_write),
        .wd  (result),
        .rd1 (rs1_val),
        .rd2 (rs2_val),
        .a0  (a0),
        .a1  (a1),
        .a7  (a7)
    );

    // NOTE: every output gets a default first, so no path through the case infers a latch.
    always_comb begin
        reg_write = 1'b0;
        alu_src   = 1'b0;
        alu_ctrl  = ALU_ADD;
        imm_sel   = IMM_I;
        res_sel   = RES_ALU;
        pc_base   = PC_PLUS4;
        mem_write = 1'b0;
        mode_bu   = 3'b000;
        is_branch = 1'b0;
        case (opcode)
            OP_R: begin
                reg_write = 1'b1;
                alu_ctrl  = arith_op(funct3, alt);
            end
            OP_I: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                alu_ctrl  = arith_op(funct3, (funct3 == F3_SR) && alt);
            end
            OP_LOAD: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                res_sel   = RES_MEM;
                mode_bu   = funct3;
            end
            OP_STORE: begin
                alu_src   = 1'b1;
                imm_sel   = IMM_S;
                mem_write = 1'b1;
                mode_bu   = funct3;
            end
            OP_BRANCH: begin
                imm_sel   = IMM_B;
                is_branch = 1'b1;
                case (funct3)
                    F3_BEQ, F3_BNE:   alu_ctrl = ALU_SUB;
                    F3_BLT, F3_BGE:   alu_ctrl = ALU_SLT;
                    F3_BLTU, F3_BGEU: alu_ctrl = ALU_SLTU;
                    default:          alu_ctrl = ALU_ADD;
                endcase
            end
            OP_JAL: begin
                reg_write = 1'b1;
                imm_sel   = IMM_J;
                pc_base   = PC_IMM;
                res_sel   = RES_PC4;
            end
            OP_JALR: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                pc_base   = PC_ALU;
                res_sel   = RES_PC4;
            end
            OP_LUI: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                imm_sel   = IMM_U;
                alu_ctrl  = ALU_PASSB;
            end
            OP_AUIPC: begin
                reg_write = 1'b1;
                imm_sel   = IMM_U;
                res_sel   = RES_PCIMM;
            end
            default: ;
        endcase
    end

    logic [WIDTH-1:0] src_b;
    logic [4:0]       shamt;

    always_comb begin
        src_b = alu_src ? imm_ext : rs2_val;
        shamt = src_b[4:0];
        case (alu_ctrl)
            ALU_ADD:   alu_result = rs1_val + src_b;
            ALU_SUB:   alu_result = rs1_val - src_b;
            ALU_AND:   alu_result = rs1_val & src_b;
            ALU_OR:    alu_result = rs1_val | src_b;
            ALU_XOR:   alu_result = rs1_val ^ src_b;
            ALU_SLT:   alu_result = WIDTH'($signed(rs1_val) < $signed(src_b));
            ALU_SLTU:  alu_result = WIDTH'(rs1_val < src_b);
            ALU_SLL:   alu_result = rs1_val << shamt;
            ALU_SRL:   alu_result = rs1_val >> shamt;
            ALU_SRA:   alu_result = $unsigned($signed(rs1_val) >>> shamt);
            ALU_PASSB: alu_result = src_b;
            default:   alu_result = '0;
        endcase
    end

    assign zero = (alu_result == '0);

    // SLT/SLTU leave the comparison in bit 0, so blt/bge family tests that bit.
    logic taken;

    always_comb begin
        taken = 1'b0;
        if (is_branch) begin
            case (funct3)
                F3_BEQ:           taken = zero;
                F3_BNE:           taken = !zero;
                F3_BLT, F3_BLTU:  taken = alu_result[0];
                F3_BGE, F3_BGEU:  taken = !alu_result[0];
                default:          taken = 1'b0;
            endcase
        end
        pc_src = taken ? PC_IMM : pc_base;
    end

    always_comb begin
        case (res_sel)
            RES_MEM:   result = read_data;
            RES_PC4:   result = pc + WIDTH'(4);
            RES_PCIMM: result = pc + imm_ext;
            default:   result = alu_result;
        endcase
    end

    assign imm_src    = imm_sel;
    assign write_data = rs2_val;

endmodule

// File: tb/tb_rv32i_decode_exec.sv
// Self-checking bench: directed scenarios then random instructions, each compared
// against an instruction-level reference model holding the architectural registers.
module tb_rv32i_decode_exec;

    localparam logic [6:0] O_R = 7'b0110011, O_I = 7'b0010011, O_LD = 7'b0000011,
                           O_ST = 7'b0100011, O_BR = 7'b1100011, O_JAL = 7'b1101111,
                           O_JALR = 7'b1100111, O_LUI = 7'b0110111, O_AUIPC = 7'b0010111;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr, pc, imm_ext, read_data;
    logic [2:0]  imm_src, mode_bu;
    logic [1:0]  pc_src;
    logic        mem_write, zero;
    logic [31:0] alu_result, write_data, result, a0, a1, a7;

    rv32i_decode_exec dut (
        .clk        (clk),
        .rst        (rst),
        .instr      (instr),
        .pc         (pc),
        .imm_ext    (imm_ext),
        .read_data  (read_data),
        .imm_src    (imm_src),
        .pc_src     (pc_src),
        .mem_write  (mem_write),
        .mode_bu    (mode_bu),
        .alu_result (alu_result),
        .zero       (zero),
        .write_data (write_data),
        .result     (result),
        .a0         (a0),
        .a1         (a1),
        .a7         (a7)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [31:0] mregs [32];

    typedef struct packed {
        logic [31:0] alu, res, wd;
        logic [1:0]  pcs;
        logic [2:0]  imms, mode;
        logic        memw, we, chk_alu, zero;
    } exp_t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (instr=%h pc=%h)", tag, got, want, instr, pc);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, O_R};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_b(input logic [4:0] rs2, rs1, input logic [2:0] f3);
        return {7'b0, rs2, rs1, f3, 5'b01000, O_BR};
    endfunction

    // Immediate extender as the surrounding datapath would supply it.
    function automatic logic [31:0] ext(input logic [31:0] i);
        case (i[6:0])
            O_ST:          return {{20{i[31]}}, i[31:25], i[11:7]};
            O_BR:          return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            O_LUI, O_AUIPC: return {i[31:12], 12'b0};
            O_JAL:         return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default:       return {{20{i[31]}}, i[31:20]};
        endcase
    endfunction

    function automatic logic [31:0] int_op(input logic [2:0] f3, input logic alt,
                                           input logic [31:0] x, input logic [31:0] y);
        case (f3)
            3'd0:    return alt ? x - y : x + y;
            3'd1:    return x << y[4:0];
            3'd2:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            3'd3:    return (x < y) ? 32'd1 : 32'd0;
            3'd4:    return x ^ y;
            3'd5:    return alt ? $unsigned($signed(x) >>> y[4:0]) : x >> y[4:0];
            3'd6:    return x | y;
            default: return x & y;
        endcase
    endfunction

    function automatic exp_t predict(input logic [31:0] i, input logic [31:0] p,
                                     input logic [31:0] rdv);
        exp_t e;
        logic [31:0] a, b, imm;
        logic [2:0]  f3;
        logic        tk;
        a = mregs[i[19:15]];
        b = mregs[i[24:20]];
        imm = ext(i);
        f3 = i[14:12];
        tk = 1'b0;
        e = '0;
        e.wd = b;
        e.chk_alu = 1'b1;
        e.alu = a + b;
        case (i[6:0])
            O_R:   begin e.we = 1; e.alu = int_op(f3, i[30], a, b); e.res = e.alu; end
            O_I:   begin e.we = 1; e.alu = int_op(f3, f3 == 3'd5 && i[30], a, imm); e.res = e.alu; end
            O_LD:  begin e.we = 1; e.alu = a + imm; e.res = rdv; e.mode = f3; end
            O_ST:  begin e.memw = 1; e.alu = a + imm; e.mode = f3; e.imms = 3'd1; end
            O_BR: begin
                e.imms = 3'd2;
                case (f3)
                    3'd0: begin e.alu = a - b; tk = (a == b); end
                    3'd1: begin e.alu = a - b; tk = (a != b); end
                    3'd4: begin tk = $signed(a) < $signed(b);  e.alu = {31'b0, tk}; end
                    3'd5: begin tk = $signed(a) >= $signed(b); e.alu = {31'b0, !tk}; end
                    3'd6: begin tk = a < b;  e.alu = {31'b0, tk}; end
                    default: begin tk = a >= b; e.alu = {31'b0, !tk}; end
                endcase
                e.pcs = tk ? 2'b01 : 2'b00;
            end
            O_JAL:   begin e.imms = 3'd4; e.pcs = 2'b01; e.we = 1; e.res = p + 4; e.chk_alu = 0; end
            O_JALR:  begin e.alu = a + imm; e.pcs = 2'b10; e.we = 1; e.res = p + 4; end
            O_LUI:   begin e.imms = 3'd3; e.alu = imm; e.res = imm; e.we = 1; end
            O_AUIPC: begin e.imms = 3'd3; e.res = p + imm; e.we = 1; e.chk_alu = 0; end
            default: ;
        endcase
        e.zero = (e.alu == 32'd0);
        return e;
    endfunction

    task automatic run(input logic [31:0] i, input logic [31:0] p, input logic [31:0] rdv);
        exp_t e;
        instr = i;
        pc = p;
        imm_ext = ext(i);
        read_data = rdv;
        e = predict(i, p, rdv);
        @(negedge clk);
        check("imm_src", {29'b0, imm_src}, {29'b0, e.imms});
        check("pc_src", {30'b0, pc_src}, {30'b0, e.pcs});
        check("mem_write", {31'b0, mem_write}, {31'b0, e.memw});
        check("mode_bu", {29'b0, mode_bu}, {29'b0, e.mode});
        check("write_data", write_data, e.wd);
        if (e.chk_alu) begin
            check("alu_result", alu_result, e.alu);
            check("zero", {31'b0, zero}, {31'b0, e.zero});
        end
        if (e.we) check("result", result, e.res);
        @(posedge clk);
        #1;
        if (e.we && i[11:7] != 5'd0) mregs[i[11:7]] = e.res;
        check("a0", a0, mregs[10]);
        check("a1", a1, mregs[11]);
        check("a7", a7, mregs[17]);
    endtask

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(4))
            0:       return 5'd10;
            1:       return 5'd11;
            2:       return 5'd17;
            default: return 5'($urandom_range(31));
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] i;
        logic [2:0]  bf [6];
        bf = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        i = $urandom;
        i[11:7]  = pick_reg();
        i[19:15] = pick_reg();
        i[24:20] = pick_reg();
        case ($urandom_range(10))
            0, 1: begin
                i[6:0] = O_R;
                i[31:25] = ((i[14:12] == 3'd0 || i[14:12] == 3'd5) && $urandom_range(1) == 1) ? 7'h20 : 7'h00;
            end
            2: begin
                i[6:0] = O_I;
                if (i[14:12] == 3'd1) i[31:25] = 7'h00;
                if (i[14:12] == 3'd5) i[31:25] = ($urandom_range(1) == 1) ? 7'h20 : 7'h00;
            end
            3, 4: i[6:0] = O_LD;
            5:    i[6:0] = O_ST;
            6, 7: begin
                i[6:0] = O_BR;
                i[14:12] = bf[$urandom_range(5)];
                if ($urandom_range(3) == 0) i[24:20] = i[19:15];
            end
            8: begin
                if ($urandom_range(1) == 1) i[6:0] = O_JAL;
                else begin i[6:0] = O_JALR; i[14:12] = 3'd0; end
            end
            9:       i[6:0] = ($urandom_range(1) == 1) ? O_LUI : O_AUIPC;
            default: i[6:0] = ($urandom_range(1) == 1) ? 7'b0001111 : 7'b1110011;
        endcase
        return i;
    endfunction

    initial begin
        for (int r = 0; r < 32; r++) mregs[r] = '0;
        rst = 1'b1;
        instr = '0; pc = '0; imm_ext = '0; read_data = '0;
        #12;
        check("rst_a0", a0, 32'd0);
        check("rst_a1", a1, 32'd0);
        check("rst_a7", a7, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run(32'h0FF00513, 32'h0, 32'h0);                       // addi x10,x0,255
        check("addi_a0", a0, 32'h000000FF);
        run(enc_i(12'h100, 5'd0, 3'd0, 5'd11, O_I), 32'h4, 0);  // addi x11,x0,0x100
        run(enc_r(7'h20, 5'd11, 5'd10, 3'd0, 5'd17), 32'h8, 0); // sub x17,x10,x11
        check("sub_a7", a7, 32'hFFFFFFFF);
        run(enc_r(7'h00, 5'd11, 5'd10, 3'd3, 5'd17), 32'hC, 0); // sltu x17,x10,x11
        check("sltu_a7", a7, 32'h1);
        run({20'h80000, 5'd17, O_LUI}, 32'h10, 0);             // lui x17,0x80000
        run(enc_i(12'd4, 5'd0, 3'd0, 5'd12, O_I), 32'h14, 0);   // addi x12,x0,4
        run(enc_r(7'h20, 5'd12, 5'd17, 3'd5, 5'd17), 32'h18, 0); // sra x17,x17,x12
        check("sra_a7", a7, 32'hF8000000);
        run(enc_i(12'd7, 5'd0, 3'd0, 5'd0, O_I), 32'h1C, 0);    // addi x0,x0,7
        check("x0_a0", a0, 32'h000000FF);

        run(enc_i(12'd3, 5'd0, 3'd0, 5'd10, O_I), 32'h20, 0);
        run(enc_i(12'd3, 5'd0, 3'd0, 5'd11, O_I), 32'h24, 0);
        run(enc_b(5'd11, 5'd10, 3'd0), 32'h28, 0);              // beq taken
        run(enc_i(12'd4, 5'd0, 3'd0, 5'd11, O_I), 32'h2C, 0);
        run(enc_b(5'd11, 5'd10, 3'd1), 32'h30, 0);              // bne taken
        run(enc_b(5'd11, 5'd10, 3'd4), 32'h34, 0);              // blt taken
        run(enc_b(5'd11, 5'd10, 3'd5), 32'h38, 0);              // bge not taken

        run({1'b0, 10'd4, 1'b0, 8'd0, 5'd1, O_JAL}, 32'h40, 0); // jal x1,+8
        check("jal_x1", mregs[1], 32'h44);
        run({7'd0, 5'd11, 5'd10, 3'd2, 5'd0, O_ST}, 32'h48, 0); // sw x11,0(x10)
        run(enc_i(12'd0, 5'd10, 3'd2, 5'd17, O_LD), 32'h4C, 32'hDEADBEEF);
        check("lw_a7", a7, 32'hDEADBEEF);
        run({20'h12345, 5'd10, O_LUI}, 32'h50, 0);
        check("lui_a0", a0, 32'h12345000);
        run({20'hABCDE, 5'd11, 7'b1111111}, 32'h54, 0);         // unknown opcode

        run(enc_i(12'd5, 5'd0, 3'd0, 5'd10, O_I), 32'h58, 0);   // x10 = 5
        check("pre_rst_a0", a0, 32'd5);
        instr = enc_i(12'd9, 5'd0, 3'd0, 5'd10, O_I);
        imm_ext = ext(instr);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_a0", a0, 32'd0);
        @(posedge clk);
        #1;
        check("rst_hold_a0", a0, 32'd0);
        check("rst_hold_a7", a7, 32'd0);
        rst = 1'b0;
        for (int r = 0; r < 32; r++) mregs[r] = '0;
        run(enc_r(7'h00, 5'd11, 5'd10, 3'd0, 5'd17), 32'h5C, 0);

        for (int n = 0; n < 600; n++) begin
            run(rand_instr(), {$urandom_range(32'h0FFF_FFFF), 2'b00}, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
